// File: rtl/uart_rx_oversampler.sv
// UART receiver: 16x oversampled serial line, 3-sample majority vote per bit,
// optional parity and one stop bit, parallel word with valid/error flags.
module uart_rx_oversampler #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RXD,
  input  logic                  RX_tick,
  input  logic                  PARITY_EN,
  output logic [DATA_WIDTH-1:0] RXDATA,
  output logic                  VALID_RX,
  output logic                  PARITY_ERROR,
  output logic                  STOP_ERROR,
  output logic                  busy
);

  localparam int unsigned BitCntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BitCntW-1:0] LastBit = BitCntW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                state_q, state_d;
  logic                  rxd_meta_q, rxd_sync_q;
  logic [3:0]            tick_cnt_q, tick_cnt_d;
  logic [BitCntW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [2:0]            samples_q, samples_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_en_q, par_en_d;
  logic                  par_fail_q, par_fail_d;
  logic [DATA_WIDTH-1:0] rxdata_q, rxdata_d;
  logic                  valid_q, valid_d;
  logic                  perr_q, perr_d;
  logic                  serr_q, serr_d;
  logic                  maj;
  logic                  slot_sample, slot_end;

  // Third vote is the live synced value on the decision tick itself.
  assign maj = (samples_q[1] & samples_q[0]) | (samples_q[1] & rxd_sync_q) |
               (samples_q[0] & rxd_sync_q);
  assign slot_sample = (tick_cnt_q == 4'd13) || (tick_cnt_q == 4'd14);
  assign slot_end    = (tick_cnt_q == 4'd15);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
    end else begin
      rxd_meta_q <= RXD;
      rxd_sync_q <= rxd_meta_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    samples_d  = samples_q;
    shift_d    = shift_q;
    par_en_d   = par_en_q;
    par_fail_d = par_fail_q;
    rxdata_d   = rxdata_q;
    perr_d     = perr_q;
    serr_d     = serr_q;
    valid_d    = 1'b0;
    if (RX_tick) begin
      unique case (state_q)
        StIdle: begin
          if (!rxd_sync_q) begin
            state_d    = StStart;
            tick_cnt_d = 4'd0;
          end
        end
        StStart: begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd7 || tick_cnt_q == 4'd8) begin
            samples_d = {samples_q[1:0], rxd_sync_q};
          end
          if (tick_cnt_q == 4'd9) begin
            if (maj) begin
              state_d = StIdle;
            end else begin
              state_d    = StData;
              tick_cnt_d = 4'd0;
              bit_cnt_d  = '0;
              par_en_d   = PARITY_EN;
              par_fail_d = 1'b0;
            end
          end
        end
        StData: begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (slot_sample) samples_d = {samples_q[1:0], rxd_sync_q};
          if (slot_end) begin
            shift_d   = {maj, shift_q[DATA_WIDTH-1:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == LastBit) state_d = par_en_q ? StParity : StStop;
          end
        end
        StParity: begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (slot_sample) samples_d = {samples_q[1:0], rxd_sync_q};
          if (slot_end) begin
            par_fail_d = ((^shift_q) ^ maj) != PARITY_ODD;
            state_d    = StStop;
          end
        end
        StStop: begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (slot_sample) samples_d = {samples_q[1:0], rxd_sync_q};
          // Return to idle mid-stop so the next start edge is caught with margin.
          if (slot_end) begin
            state_d  = StIdle;
            rxdata_d = shift_q;
            perr_d   = par_fail_q;
            serr_d   = ~maj;
            valid_d  = ~par_fail_q & maj;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= StIdle;
      tick_cnt_q <= 4'd0;
      bit_cnt_q  <= '0;
      samples_q  <= 3'b111;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_fail_q <= 1'b0;
      rxdata_q   <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      serr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      samples_q  <= samples_d;
      shift_q    <= shift_d;
      par_en_q   <= par_en_d;
      par_fail_q <= par_fail_d;
      rxdata_q   <= rxdata_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      serr_q     <= serr_d;
    end
  end

  assign RXDATA       = rxdata_q;
  assign VALID_RX     = valid_q;
  assign PARITY_ERROR = perr_q;
  assign STOP_ERROR   = serr_q;
  assign busy         = (state_q != StIdle);

endmodule
